// File: rtl/uart_pkg.sv
// Shared UART definitions: framer states, the expected hello message and counter limits.
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int MESSAGE_LEN = 8;

  localparam logic [7:0] MSG [MESSAGE_LEN] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h21, 8'h0A
  };

  localparam logic [7:0] SAT_MAX = 8'd255;

endpackage

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// 8N1 serial deframer: two-flop input synchronizer plus mid-bit sampling state machine.
`default_nettype none

module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = 4
) (
  input  logic       ser_clk,
  input  logic       rst_n,
  input  logic       SER_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int TW = $clog2(clocks_per_bit);
  localparam logic [TW-1:0] HALF_LOAD = TW'(clocks_per_bit / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(clocks_per_bit - 1);

  logic            sync_1;
  logic            rx_s;
  rx_state_t       state;
  logic [TW-1:0]   bit_timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  always_ff @(posedge ser_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1       <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      bit_timer    <= '0;
      bit_idx      <= 3'd0;
      shift        <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync_1       <= SER_RX;
      rx_s         <= sync_1;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state     <= START;
            bit_timer <= HALF_LOAD;
          end
        end

        START: begin
          if (bit_timer != '0) begin
            bit_timer <= bit_timer - 1'b1;
          end else if (!rx_s) begin
            state     <= DATA;
            bit_timer <= FULL_LOAD;
            bit_idx   <= 3'd0;
          end else begin
            state <= IDLE;
          end
        end

        DATA: begin
          if (bit_timer != '0) begin
            bit_timer <= bit_timer - 1'b1;
          end else begin
            shift     <= {rx_s, shift[7:1]};
            bit_timer <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        STOP: begin
          if (bit_timer != '0) begin
            bit_timer <= bit_timer - 1'b1;
          end else if (rx_s) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            rx_frame_err <= 1'b1;
            state        <= WAIT_HIGH;
          end
        end

        // A held-low line (break) must rise before another start can be detected.
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_hello_check.sv
// Receives 8N1 bytes and checks them against the fixed hello message, counting good messages and errors.
`default_nettype none

module uart_hello_check
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = 4,
  parameter int message_len    = 8
) (
  input  logic       ser_clk,
  input  logic       rst_n,
  input  logic       SER_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       msg_ok,
  output logic [7:0] msg_count,
  output logic [7:0] err_count,
  output logic [7:0] LEDS
);

  localparam int CW = (message_len > 1) ? $clog2(message_len) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(message_len - 1);

  logic [CW-1:0] cursor;

  uart_rx_frame #(
    .clocks_per_bit(clocks_per_bit)
  ) u_frame (
    .ser_clk     (ser_clk),
    .rst_n       (rst_n),
    .SER_RX      (SER_RX),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  always_ff @(posedge ser_clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor    <= '0;
      msg_ok    <= 1'b0;
      msg_count <= 8'h00;
      err_count <= 8'h00;
    end else begin
      msg_ok <= 1'b0;
      if (rx_valid) begin
        if (rx_data == MSG[cursor]) begin
          if (cursor == LAST_IDX) begin
            msg_ok <= 1'b1;
            cursor <= '0;
            if (msg_count != SAT_MAX) msg_count <= msg_count + 8'd1;
          end else begin
            cursor <= cursor + 1'b1;
          end
        end else begin
          if (err_count != SAT_MAX) err_count <= err_count + 8'd1;
          // A stray byte that is itself the message head restarts matching after it.
          cursor <= (rx_data == MSG[0]) ? CW'(1) : '0;
        end
      end else if (rx_frame_err) begin
        if (err_count != SAT_MAX) err_count <= err_count + 8'd1;
        cursor <= '0;
      end
    end
  end

  assign LEDS = msg_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_hello_check.sv
// Directed bench for uart_hello_check: serial stimulus with hand-computed expectations.
`default_nettype none

module tb_uart_hello_check;

  localparam int CPB = 4;

  logic       ser_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       SER_RX  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       msg_ok;
  logic [7:0] msg_count;
  logic [7:0] err_count;
  logic [7:0] LEDS;

  int n_cmp  = 0;
  int n_fail = 0;

  // Running event tallies sampled on the falling edge.
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_ok    = 0;
  logic [7:0] got_bytes [1024];

  uart_hello_check #(
    .clocks_per_bit(CPB),
    .message_len   (8)
  ) dut (
    .ser_clk     (ser_clk),
    .rst_n       (rst_n),
    .SER_RX      (SER_RX),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .msg_ok      (msg_ok),
    .msg_count   (msg_count),
    .err_count   (err_count),
    .LEDS        (LEDS)
  );

  always #5 ser_clk = ~ser_clk;

  always @(negedge ser_clk) begin
    if (rx_valid) begin
      if (n_valid < 1024) got_bytes[n_valid] = rx_data;
      n_valid = n_valid + 1;
    end
    if (rx_frame_err) n_ferr = n_ferr + 1;
    if (msg_ok) n_ok = n_ok + 1;
  end

  task automatic do_reset();
    @(negedge ser_clk);
    rst_n  = 1'b0;
    SER_RX = 1'b1;
    repeat (3) @(negedge ser_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge ser_clk);
  endtask

  task automatic send_bit(input logic b);
    SER_RX = b;
    repeat (CPB) @(negedge ser_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    SER_RX = 1'b1;
    repeat (n) @(negedge ser_clk);
  endtask

  task automatic test_reset();
    @(negedge ser_clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %0h expected 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %0b expected 0", rx_valid); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %0b expected 0", rx_frame_err); end
    n_cmp++; if (msg_ok !== 1'b0) begin n_fail++; $display("FAIL reset_msg_ok: got %0b expected 0", msg_ok); end
    n_cmp++; if (msg_count !== 8'h00) begin n_fail++; $display("FAIL reset_msg_count: got %0h expected 00", msg_count); end
    n_cmp++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err_count: got %0h expected 00", err_count); end
    n_cmp++; if (LEDS !== 8'h00) begin n_fail++; $display("FAIL reset_leds: got %0h expected 00", LEDS); end
    repeat (2) @(negedge ser_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge ser_clk);
  endtask

  task automatic test_clean_message();
    logic [7:0] exp_msg [8] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h21, 8'h0A};
    int v0, ok0;
    do_reset();
    v0 = n_valid; ok0 = n_ok;
    for (int i = 0; i < 8; i++) send_byte(exp_msg[i], 1'b1);
    idle(12);
    n_cmp++; if (n_valid - v0 !== 8) begin n_fail++; $display("FAIL clean_valid_count: got %0d expected 8", n_valid - v0); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got_bytes[v0 + i] !== exp_msg[i]) begin
        n_fail++; $display("FAIL clean_byte%0d: got %0h expected %0h", i, got_bytes[v0 + i], exp_msg[i]);
      end
    end
    n_cmp++; if (n_ok - ok0 !== 1) begin n_fail++; $display("FAIL clean_msg_ok: got %0d expected 1", n_ok - ok0); end
    n_cmp++; if (msg_count !== 8'd1) begin n_fail++; $display("FAIL clean_msg_count: got %0h expected 01", msg_count); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL clean_err_count: got %0h expected 00", err_count); end
    n_cmp++; if (LEDS !== 8'h01) begin n_fail++; $display("FAIL clean_leds: got %0h expected 01", LEDS); end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    do_reset();
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h55, 1'b0);
    SER_RX = 1'b0;
    repeat (20) @(negedge ser_clk);
    idle(8);
    n_cmp++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d expected 1", n_ferr - f0); end
    n_cmp++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d expected 0", n_valid - v0); end
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL ferr_err_count: got %0h expected 01", err_count); end
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL ferr_rx_data_held: got %0h expected 00", rx_data); end
    send_byte(8'h48, 1'b1);
    idle(12);
    n_cmp++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL ferr_recover_valid: got %0d expected 1", n_valid - v0); end
    n_cmp++; if (rx_data !== 8'h48) begin n_fail++; $display("FAIL ferr_recover_data: got %0h expected 48", rx_data); end
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL ferr_recover_err: got %0h expected 01", err_count); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    do_reset();
    v0 = n_valid; f0 = n_ferr;
    SER_RX = 1'b0;
    @(negedge ser_clk);
    idle(60);
    n_cmp++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", n_valid - v0); end
    n_cmp++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected 0", n_ferr - f0); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL glitch_err_count: got %0h expected 00", err_count); end
    n_cmp++; if (msg_count !== 8'd0) begin n_fail++; $display("FAIL glitch_msg_count: got %0h expected 00", msg_count); end
  endtask

  task automatic test_mismatch_resync();
    logic [7:0] seq [9] = '{8'h48, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h21, 8'h0A};
    int ok0;
    do_reset();
    ok0 = n_ok;
    for (int i = 0; i < 9; i++) send_byte(seq[i], 1'b1);
    idle(12);
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL resync_err_count: got %0h expected 01", err_count); end
    n_cmp++; if (n_ok - ok0 !== 1) begin n_fail++; $display("FAIL resync_msg_ok: got %0d expected 1", n_ok - ok0); end
    n_cmp++; if (msg_count !== 8'd1) begin n_fail++; $display("FAIL resync_msg_count: got %0h expected 01", msg_count); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'h6C;
    int v0, f0;
    do_reset();
    send_byte(8'h48, 1'b1);
    send_byte(8'h11, 1'b1);
    idle(12);
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL midrst_pre_err: got %0h expected 01", err_count); end
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    SER_RX = b[4];
    repeat (2) @(negedge ser_clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data: got %0h expected 00", rx_data); end
    n_cmp++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL midrst_err_count: got %0h expected 00", err_count); end
    n_cmp++; if ({rx_valid, rx_frame_err, msg_ok} !== 3'b000) begin n_fail++; $display("FAIL midrst_pulses: got %0b expected 000", {rx_valid, rx_frame_err, msg_ok}); end
    n_cmp++; if (LEDS !== 8'h00) begin n_fail++; $display("FAIL midrst_leds: got %0h expected 00", LEDS); end
    SER_RX = 1'b1;
    repeat (3) @(negedge ser_clk);
    rst_n = 1'b1;
    v0 = n_valid; f0 = n_ferr;
    idle(20);
    send_byte(8'h6C, 1'b1);
    idle(12);
    n_cmp++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL midrst_valid: got %0d expected 1", n_valid - v0); end
    n_cmp++; if (rx_data !== 8'h6C) begin n_fail++; $display("FAIL midrst_data: got %0h expected 6c", rx_data); end
    n_cmp++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL midrst_ferr: got %0d expected 0", n_ferr - f0); end
  endtask

  task automatic test_saturation();
    int v0;
    do_reset();
    v0 = n_valid;
    for (int i = 0; i < 260; i++) send_byte(8'h00, 1'b1);
    idle(12);
    n_cmp++; if (n_valid - v0 !== 260) begin n_fail++; $display("FAIL sat_valid_count: got %0d expected 260", n_valid - v0); end
    n_cmp++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_err_count: got %0d expected 255", err_count); end
    n_cmp++; if (msg_count !== 8'd0) begin n_fail++; $display("FAIL sat_msg_count: got %0d expected 0", msg_count); end
  endtask

  initial begin
    test_reset();
    test_clean_message();
    test_frame_error();
    test_glitch();
    test_mismatch_resync();
    test_reset_mid_frame();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/uart_hello_check.md
# uart_hello_check

Serial receiver and message checker for the far end of the UART link driven by the hello-message transmitter. It deframes 8N1 serial bytes from `SER_RX` and verifies them against the fixed 8-byte message "Hello!!\n". It counts complete good messages and errors, and drives the count to `LEDS`. The block sits on the board-level serial input and is the loopback and self-test partner of the transmitter.

## Interface
Parameters:
- `clocks_per_bit`, default 4: `ser_clk` cycles per serial bit; even, ≥ 4.
- `message_len`, default 8: expected message length in bytes.

Ports:
- `ser_clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `SER_RX`, in, 1: serial line; idles high; LSB first; 1 start, 8 data, 1 stop bit.
- `rx_data`, out, 8: last received byte; holds until the next good byte.
- `rx_valid`, out, 1: one-cycle pulse when a good frame completes.
- `rx_frame_err`, out, 1: one-cycle pulse when the stop bit samples 0.
- `msg_ok`, out, 1: one-cycle pulse when the last byte of a matching message completes.
- `msg_count`, out, 8: count of good messages; saturates at 255.
- `err_count`, out, 8: count of mismatched bytes plus framing errors; saturates at 255.
- `LEDS`, out, 8: equals `msg_count`.

## Operation
- **Input synchronizer.** `SER_RX` passes through a 2-flop synchronizer. Both flops reset to 1. All logic below uses the synchronized value `rx_s`.
- **Framer state machine.** States are IDLE, START, DATA, STOP and WAIT_HIGH. One down-counter `bit_timer` is sized $clog2(clocks_per_bit). One 3-bit index `bit_idx` tracks the data bit.
  - IDLE: when `rx_s` is 0, go to START and load `bit_timer` = clocks_per_bit/2 − 1.
  - START: when `bit_timer` is 0, sample `rx_s`.
    - Sample 0: go to DATA, load `bit_timer` = clocks_per_bit − 1, clear `bit_idx`.
    - Sample 1: treat as a glitch and return to IDLE. No outputs fire and no counter changes.
  - DATA: when `bit_timer` is 0, shift `rx_s` into `shift[7]` (right shift, LSB first) and reload `bit_timer`.
    - When `bit_idx` is 7, go to STOP.
    - Otherwise increment `bit_idx`.
  - STOP: when `bit_timer` is 0, sample `rx_s`.
    - Sample 1: set `rx_data` to `shift`, pulse `rx_valid`, go to IDLE.
    - Sample 0: pulse `rx_frame_err` and go to WAIT_HIGH. `rx_data` is unchanged.
  - WAIT_HIGH: stay until `rx_s` is 1, then go to IDLE. This prevents a break condition from retriggering start detection.
- **Checker.** `cursor` runs from 0 to message_len − 1. Expected bytes are `MSG[cursor]`.
  - On `rx_valid` with `rx_data` equal to `MSG[cursor]`:
    - If `cursor` is message_len − 1: pulse `msg_ok` the next cycle, increment `msg_count` (saturating), set `cursor` to 0.
    - Otherwise increment `cursor`.
  - On `rx_valid` with a mismatch: increment `err_count` (saturating). Set `cursor` to 1 if `rx_data` equals `MSG[0]`, else 0.
  - On `rx_frame_err`: increment `err_count` (saturating) and set `cursor` to 0.
  - `rx_valid` and `rx_frame_err` are mutually exclusive by construction.
- **Reset values.** All outputs reset to 0. Internal state resets to: state IDLE, `cursor` 0, `shift` 0, synchronizer flops 1.
- **Reset mid-frame.** The partial frame is discarded silently, with no pulse and no count change. Reception resumes at the next falling edge after release.

## Timing
- Synchronizer latency: 2 cycles from the `SER_RX` pin to `rx_s`.
- Let cycle E be the first cycle in IDLE with `rx_s` = 0. Then:
  - Start sample at E + clocks_per_bit/2.
  - Data bit k sample at E + clocks_per_bit/2 + (k+1)·clocks_per_bit, for k = 0..7.
  - Stop sample at E + clocks_per_bit/2 + 9·clocks_per_bit.
- `rx_valid` / `rx_frame_err` are registered and high for the single cycle after the stop sample.
- `msg_ok`, `msg_count` and `err_count` update one cycle after `rx_valid` / `rx_frame_err`.
- Back-to-back frames: IDLE is re-entered at least clocks_per_bit/2 − 1 cycles before the next start edge. The framer accepts the transmitter's continuous stream with no inter-frame gap.
- Glitch rejection: a low pulse shorter than clocks_per_bit/2 cycles at `rx_s` produces no event.

## Structure
- Shared package `uart_pkg` holds:
  - the framer state enum;
  - the `MSG` constant array (0x48 0x65 0x6C 0x6C 0x6F 0x21 0x21 0x0A) and `MESSAGE_LEN`, shared with the transmitter side;
  - the `SAT_MAX` (255) constant.
- Sub-module `uart_rx_frame` contains the synchronizer and framer, with outputs `rx_data`, `rx_valid` and `rx_frame_err`. The top level holds the checker and the counters.

## Test plan
- **Clean message:** clocks_per_bit = 4, send "Hello!!\n" back-to-back → 8 `rx_valid` pulses with `rx_data` 0x48 … 0x0A, one `msg_ok`, `msg_count` = 1, `err_count` = 0, `LEDS` = 0x01.
- **Framing error:** send 0x55 with stop bit 0, then hold the line low for 20 cycles → one `rx_frame_err`, `err_count` = 1, no `rx_valid`. The framer stays in WAIT_HIGH until the line rises; a following clean 0x48 is received correctly.
- **Glitch:** drive a 1-cycle low pulse on `SER_RX` → no `rx_valid`, no `rx_frame_err`, counters unchanged.
- **Mismatch with resync:** send 0x48 0x48 then "ello!!\n" → `err_count` = 1, `msg_ok` once, `msg_count` = 1.
- **Reset mid-frame:** assert `rst_n` low during bit 4 of 0x6C → all outputs 0 immediately. After release, a clean 0x6C gives `rx_valid` with `rx_data` = 0x6C.
- **Saturation:** 260 mismatching bytes (0x00) → `err_count` holds at 255 and `msg_count` remains 0.
